// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem request/response handshake, in-order queue.
// Optional FETCH_PERF_EN adds saturating fetched/bubble counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h1000_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h7800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] out_PC_next,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] q_head, q_tail;
  logic [AW-1:0] a_head, a_tail;
  logic [31:0]   q_word [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   a_addr [QDEPTH];

  logic [CW:0] used;
  logic        rsp, issue, push, pop;
  logic        is_boot, flush_rsp;

  assign used = {1'b0, outst_q} + {1'b0, count_q};
  // rvalid with nothing outstanding is spurious and has no effect
  assign rsp  = imem_rvalid && (outst_q != '0);

  assign imem_req  = (state_q == RUN) && (used < QD) && !redirect;
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  assign push = rsp && (state_q != FLUSH)
             && (drop_q == '0) && !redirect;

  assign instr_valid = (count_q != '0) && !redirect;
  assign pop         = instr_valid && !stall;
  assign instr       = instr_valid ? q_word[q_head] : NOP_INSTR;
  assign out_PC_next = instr_valid ? q_pc[q_head] : 32'd0;

  assign is_boot   = !redirect && (state_q == BOOT);
  assign flush_rsp = !redirect && (state_q == FLUSH) && rsp;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(issue) - CW'(rsp);
    fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    unique case (1'b1)
      redirect: begin
        fetch_pc_d = {redirect_pc[31:2], 2'b00};
        drop_d     = outst_q - CW'(rsp);
        state_d    = (drop_d != '0) ? FLUSH : RUN;
      end
      is_boot: state_d = RUN;
      flush_rsp: begin
        drop_d = drop_q - 1'b1;
        if (drop_d == '0) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      q_head     <= '0;
      q_tail     <= '0;
      a_head     <= '0;
      a_tail     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (issue) a_tail <= a_tail + 1'b1;
      if (rsp)   a_head <= a_head + 1'b1;
      if (redirect) begin
        q_head  <= '0;
        q_tail  <= '0;
        count_q <= '0;
      end else begin
        if (push) q_tail <= q_tail + 1'b1;
        if (pop)  q_head <= q_head + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Issued addresses stay queued across redirects so dropped responses stay aligned
  always_ff @(posedge clk) begin
    if (issue) a_addr[a_tail] <= fetch_pc_q;
    if (push) begin
      q_word[q_tail] <= imem_rdata;
      q_pc[q_tail]   <= a_addr[a_head] + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (!instr_valid && !stall && (state_q != BOOT)
          && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model
// and a log of every instruction consumed by decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] out_PC_next;
  logic        instr_valid;

  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        rsp_en;
  int          acc_cnt = 0;
  logic [31:0] last_acc = 32'd0;
  logic [31:0] pend[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_ins[$];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h7800_0000;
  localparam logic [31:0] RPC = 32'h1000_0000;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr),
    .out_PC_next(out_PC_next), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  assign imem_rvalid = mem_rvalid | man_rvalid;
  assign imem_rdata  = man_rvalid ? man_rdata : mem_rdata;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  // in-order memory: a response the cycle after grant while rsp_en is set
  always @(posedge clk) begin
    logic [31:0] a;
    if (!rst_n) begin
      pend.delete();
      mem_rvalid <= 1'b0;
    end else begin
      if (imem_req && imem_gnt) begin
        pend.push_back(imem_addr);
        acc_cnt++;
        last_acc = imem_addr;
      end
      if (rsp_en && pend.size() > 0) begin
        a = pend.pop_front();
        mem_rvalid <= 1'b1;
        mem_rdata  <= word_of(a);
      end else begin
        mem_rvalid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid && !stall) begin
      log_pc.push_back(out_PC_next);
      log_ins.push_back(instr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; imem_gnt = 1'b1; rsp_en = 1'b1;
    man_rvalid = 1'b0; man_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL rst_addr: got %h exp %h", imem_addr, RPC); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h exp %h", instr, NOP); end
    checks++; if (out_PC_next !== 32'd0) begin errors++; $display("FAIL rst_pcn: got %h exp 0", out_PC_next); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b exp 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL first_addr: got %h exp %h", imem_addr, RPC); end
    step();
    checks++; if (imem_addr !== 32'h1000_0004) begin errors++; $display("FAIL second_addr: got %h exp 10000004", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_valid0: got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat_valid1: got %b exp 1", instr_valid); end
    checks++; if (out_PC_next !== 32'h1000_0004) begin errors++; $display("FAIL first_pcn: got %h exp 10000004", out_PC_next); end
    checks++; if (instr !== word_of(RPC)) begin errors++; $display("FAIL first_instr: got %h exp %h", instr, word_of(RPC)); end
    repeat (12) step();
    checks++; if (log_pc.size() < 4) begin errors++; $display("FAIL stream_len: got %0d exp >=4", log_pc.size()); end
    for (int i = 0; i < log_pc.size(); i++) begin
      checks++;
      if (log_pc[i] !== 32'h1000_0004 + 32'(4*i) || log_ins[i] !== word_of(32'h1000_0000 + 32'(4*i))) begin
        errors++;
        $display("FAIL stream[%0d]: got pc %h ins %h exp pc %h", i, log_pc[i], log_ins[i], 32'h1000_0004 + 32'(4*i));
      end
    end
  endtask

  task automatic test_stall();
    int st, acc0;
    st = log_pc.size();
    acc0 = acc_cnt;
    stall = 1'b1;
    repeat (6) step();
    checks++; if (acc_cnt - acc0 > 2) begin errors++; $display("FAIL stall_acc: got %0d exp <=2", acc_cnt - acc0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b exp 1", instr_valid); end
    checks++; if (log_pc.size() != st) begin errors++; $display("FAIL stall_pop: got %0d exp %0d", log_pc.size(), st); end
    stall = 1'b0;
    repeat (10) step();
    checks++; if (log_pc.size() < st + 3) begin errors++; $display("FAIL stall_resume: got %0d exp >=%0d", log_pc.size(), st + 3); end
    for (int i = st; i < log_pc.size(); i++) begin
      checks++;
      if (log_pc[i] !== log_pc[i-1] + 32'd4 || log_ins[i] !== word_of(log_pc[i] - 32'd4)) begin
        errors++;
        $display("FAIL stall_order[%0d]: got pc %h exp %h", i, log_pc[i], log_pc[i-1] + 32'd4);
      end
    end
  endtask

  task automatic test_redirect_flush();
    int st, n;
    rsp_en = 1'b0;
    repeat (5) step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_credit: got %b exp 0", imem_req); end
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL rf_inflight: got %0d exp 2", pend.size()); end
    st = log_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h1000_0103;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_req_redir: got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_valid_redir: got %b exp 0", instr_valid); end
    step();
    redirect = 1'b0;
    rsp_en = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_flush_req: got %b exp 0", imem_req); end
    n = 0;
    while (!imem_req && n < 12) begin step(); n++; end
    checks++;
    if (!imem_req) begin errors++; $display("FAIL rf_restart: timeout, req %b exp 1", imem_req); end
    else if (imem_addr !== 32'h1000_0100) begin errors++; $display("FAIL rf_addr: got %h exp 10000100", imem_addr); end
    n = 0;
    while (log_pc.size() <= st && n < 12) begin step(); n++; end
    checks++;
    if (log_pc.size() <= st) begin errors++; $display("FAIL rf_deliver: timeout, got none exp 1"); end
    else if (log_pc[st] !== 32'h1000_0104 || log_ins[st] !== word_of(32'h1000_0100)) begin
      errors++; $display("FAIL rf_first: got pc %h ins %h exp pc 10000104", log_pc[st], log_ins[st]);
    end
  endtask

  task automatic test_redirect_rvalid();
    int st, n;
    rsp_en = 1'b0;
    repeat (5) step();
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL rr_inflight: got %0d exp 2", pend.size()); end
    rsp_en = 1'b1;
    step();
    st = log_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h1000_0200;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rr_req: got %b exp 0", imem_req); end
    step();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rr_flush_req: got %b exp 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rr_run_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h1000_0200) begin errors++; $display("FAIL rr_addr: got %h exp 10000200", imem_addr); end
    n = 0;
    while (log_pc.size() <= st && n < 12) begin step(); n++; end
    checks++;
    if (log_pc.size() <= st) begin errors++; $display("FAIL rr_deliver: timeout, got none exp 1"); end
    else if (log_pc[st] !== 32'h1000_0204 || log_ins[st] !== word_of(32'h1000_0200)) begin
      errors++; $display("FAIL rr_first: got pc %h ins %h exp pc 10000204", log_pc[st], log_ins[st]);
    end
  endtask

  task automatic test_gnt_low();
    int st, n;
    logic [31:0] exp_a;
    imem_gnt = 1'b0;
    repeat (6) step();
    exp_a = last_acc + 32'd4;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL gl_req[%0d]: got %b exp 1", i, imem_req); end
      checks++; if (imem_addr !== exp_a) begin errors++; $display("FAIL gl_addr[%0d]: got %h exp %h", i, imem_addr, exp_a); end
      step();
    end
    man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();
    man_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL sp_valid: got %b exp 0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL sp_instr: got %h exp %h", instr, NOP); end
    checks++; if (out_PC_next !== 32'd0) begin errors++; $display("FAIL sp_pcn: got %h exp 0", out_PC_next); end
    checks++; if (imem_addr !== exp_a) begin errors++; $display("FAIL sp_addr: got %h exp %h", imem_addr, exp_a); end
    st = log_pc.size();
    imem_gnt = 1'b1;
    n = 0;
    while (log_pc.size() <= st && n < 12) begin step(); n++; end
    checks++;
    if (log_pc.size() <= st) begin errors++; $display("FAIL gl_deliver: timeout, got none exp 1"); end
    else if (log_pc[st] !== exp_a + 32'd4 || log_ins[st] !== word_of(exp_a)) begin
      errors++; $display("FAIL gl_first: got pc %h ins %h exp pc %h", log_pc[st], log_ins[st], exp_a + 32'd4);
    end
  endtask

  task automatic test_reset_mid();
    int st, n;
    rsp_en = 1'b0;
    repeat (5) step();
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL rm_inflight: got %0d exp 2", pend.size()); end
    st = log_pc.size();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", imem_req); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL rm_addr: got %h exp %h", imem_addr, RPC); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b exp 0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL rm_instr: got %h exp %h", instr, NOP); end
    checks++; if (out_PC_next !== 32'd0) begin errors++; $display("FAIL rm_pcn: got %h exp 0", out_PC_next); end
    step();
    rsp_en = 1'b1;
    step();
    rst_n = 1'b1;
    man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL rm_restart: got req %b addr %h exp 1 %h", imem_req, imem_addr, RPC); end
    step();
    man_rvalid = 1'b0;
    n = 0;
    while (log_pc.size() <= st + 1 && n < 12) begin step(); n++; end
    checks++;
    if (log_pc.size() <= st + 1) begin errors++; $display("FAIL rm_deliver: timeout, got %0d exp 2", log_pc.size() - st); end
    else if (log_pc[st] !== 32'h1000_0004 || log_ins[st] !== word_of(RPC) || log_pc[st+1] !== 32'h1000_0008) begin
      errors++; $display("FAIL rm_first: got pc %h ins %h next %h exp 10000004", log_pc[st], log_ins[st], log_pc[st+1]);
    end
  endtask

  task automatic test_back_to_back();
    int st, n;
    st = log_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h1000_0300;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bb_req0: got %b exp 0", imem_req); end
    step();
    redirect_pc = 32'h1000_0406;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bb_req1: got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bb_valid: got %b exp 0", instr_valid); end
    step();
    redirect = 1'b0;
    #1;
    n = 0;
    while (!imem_req && n < 12) begin step(); n++; end
    checks++;
    if (!imem_req) begin errors++; $display("FAIL bb_restart: timeout, req %b exp 1", imem_req); end
    else if (imem_addr !== 32'h1000_0404) begin errors++; $display("FAIL bb_addr: got %h exp 10000404", imem_addr); end
    n = 0;
    while (log_pc.size() <= st && n < 12) begin step(); n++; end
    checks++;
    if (log_pc.size() <= st) begin errors++; $display("FAIL bb_deliver: timeout, got none exp 1"); end
    else if (log_pc[st] !== 32'h1000_0408 || log_ins[st] !== word_of(32'h1000_0404)) begin
      errors++; $display("FAIL bb_first: got pc %h ins %h exp pc 10000408", log_pc[st], log_ins[st]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_flush();
    test_redirect_rvalid();
    test_gnt_low();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
